// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the io_controller bus: serialises CPU (m0) and DMA (m1) accesses,
// issues a one-cycle strobe and captures read data RD_LAT cycles later.
module io_bus_arbiter #(
  parameter int RD_LAT     = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rd_data,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rd_data,
  output logic        bus_cs,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     r_state;
  state_t     w_nxt;
  logic       r_win;
  logic       r_last;
  logic       r_wr;
  logic [2:0] r_cnt;
  logic       w_sel;
  logic       w_new_wr;
  logic       w_win_nxt;
  logic       w_cap;
  logic       w_any;

  always_comb begin
    w_nxt     = r_state;
    w_cap     = 1'b0;
    w_any     = m0_req | m1_req;
    // Tie goes to m0 under fixed priority, otherwise to whoever did not go last
    if (m0_req && m1_req) w_sel = FIXED_PRIO ? 1'b0 : ~r_last;
    else                  w_sel = m1_req;
    w_new_wr  = w_sel ? m1_wr : m0_wr;
    w_win_nxt = (r_state == S_IDLE) ? w_sel : r_win;
    case (r_state)
      S_IDLE:  if (w_any) w_nxt = S_ISSUE;
      S_ISSUE: begin
        if (r_wr) begin
          w_nxt = S_DONE;
        end else if (RD_LAT == 0) begin
          w_cap = 1'b1;
          w_nxt = S_DONE;
        end else begin
          w_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAT) begin
          w_cap = 1'b1;
          w_nxt = S_DONE;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered and line up with the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_win       <= 1'b0;
      r_last      <= 1'b1;
      r_wr        <= 1'b0;
      r_cnt       <= 3'd0;
      m0_gnt      <= 1'b0;
      m0_done     <= 1'b0;
      m0_rd_data  <= 32'd0;
      m1_gnt      <= 1'b0;
      m1_done     <= 1'b0;
      m1_rd_data  <= 32'd0;
      bus_cs      <= 1'b0;
      bus_wr      <= 1'b0;
      bus_rd      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_wr_data <= 32'd0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_win       <= w_sel;
        r_wr        <= w_new_wr;
        bus_addr    <= w_sel ? m1_addr : m0_addr;
        bus_wr_data <= w_sel ? m1_wr_data : m0_wr_data;
      end
      if (r_state == S_ISSUE)     r_cnt <= 3'd1;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 3'd1;
      if (w_cap) begin
        if (r_win) m1_rd_data <= bus_rd_data;
        else       m0_rd_data <= bus_rd_data;
      end
      if (r_state == S_DONE) r_last <= r_win;
      bus_cs  <= (w_nxt == S_ISSUE);
      bus_wr  <= (w_nxt == S_ISSUE) && w_new_wr;
      bus_rd  <= (w_nxt == S_ISSUE) && !w_new_wr;
      m0_gnt  <= (w_nxt != S_IDLE) && !w_win_nxt;
      m1_gnt  <= (w_nxt != S_IDLE) && w_win_nxt;
      m0_done <= (w_nxt == S_DONE) && !w_win_nxt;
      m1_done <= (w_nxt == S_DONE) && w_win_nxt;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: three instances cover RD_LAT=1, RD_LAT=3 and fixed priority.
module tb_io_bus_arbiter;

  logic clk;
  logic reset;

  logic        m0_req [3];
  logic        m0_wr [3];
  logic [31:0] m0_addr [3];
  logic [31:0] m0_wr_data [3];
  logic        m0_gnt [3];
  logic        m0_done [3];
  logic [31:0] m0_rd_data [3];
  logic        m1_req [3];
  logic        m1_wr [3];
  logic [31:0] m1_addr [3];
  logic [31:0] m1_wr_data [3];
  logic        m1_gnt [3];
  logic        m1_done [3];
  logic [31:0] m1_rd_data [3];
  logic        bus_cs [3];
  logic        bus_wr [3];
  logic        bus_rd [3];
  logic [31:0] bus_addr [3];
  logic [31:0] bus_wr_data [3];
  logic [31:0] bus_rd_data [3];

  int n_chk;
  int n_err;

  // Instance 0: RD_LAT=1 round-robin, 1: RD_LAT=3 round-robin, 2: RD_LAT=1 fixed priority
  for (genvar g = 0; g < 3; g++) begin : g_dut
    io_bus_arbiter #(
      .RD_LAT     ((g == 1) ? 3 : 1),
      .FIXED_PRIO ((g == 2) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .m0_req      (m0_req[g]),
      .m0_wr       (m0_wr[g]),
      .m0_addr     (m0_addr[g]),
      .m0_wr_data  (m0_wr_data[g]),
      .m0_gnt      (m0_gnt[g]),
      .m0_done     (m0_done[g]),
      .m0_rd_data  (m0_rd_data[g]),
      .m1_req      (m1_req[g]),
      .m1_wr       (m1_wr[g]),
      .m1_addr     (m1_addr[g]),
      .m1_wr_data  (m1_wr_data[g]),
      .m1_gnt      (m1_gnt[g]),
      .m1_done     (m1_done[g]),
      .m1_rd_data  (m1_rd_data[g]),
      .bus_cs      (bus_cs[g]),
      .bus_wr      (bus_wr[g]),
      .bus_rd      (bus_rd[g]),
      .bus_addr    (bus_addr[g]),
      .bus_wr_data (bus_wr_data[g]),
      .bus_rd_data (bus_rd_data[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m0_req[i] = 1'b0; m0_wr[i] = 1'b0; m0_addr[i] = '0; m0_wr_data[i] = '0;
      m1_req[i] = 1'b0; m1_wr[i] = 1'b0; m1_addr[i] = '0; m1_wr_data[i] = '0;
      bus_rd_data[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs",     32'(bus_cs[i]), 32'd0);
      chk("rst_gnt",    32'({m0_gnt[i], m1_gnt[i]}), 32'd0);
      chk("rst_done",   32'({m0_done[i], m1_done[i]}), 32'd0);
      chk("rst_addr",   bus_addr[i], 32'd0);
      chk("rst_rddata", m0_rd_data[i] | m1_rd_data[i], 32'd0);
    end
    reset = 1'b1;

    // m0 write: strobe in cycle 1, done in cycle 2
    tick();
    m0_req[0] = 1'b1; m0_wr[0] = 1'b1; m0_addr[0] = 32'h4; m0_wr_data[0] = 32'hA5;
    tick();
    chk("wr_c1_cs",   32'(bus_cs[0]), 32'd1);
    chk("wr_c1_wr",   32'(bus_wr[0]), 32'd1);
    chk("wr_c1_rd",   32'(bus_rd[0]), 32'd0);
    chk("wr_c1_addr", bus_addr[0], 32'h4);
    chk("wr_c1_data", bus_wr_data[0], 32'hA5);
    chk("wr_c1_gnt",  32'({m0_gnt[0], m1_gnt[0]}), 32'b10);
    chk("wr_c1_done", 32'(m0_done[0]), 32'd0);
    tick();
    chk("wr_c2_cs",   32'(bus_cs[0]), 32'd0);
    chk("wr_c2_done", 32'(m0_done[0]), 32'd1);
    chk("wr_c2_gnt",  32'(m0_gnt[0]), 32'd1);
    m0_req[0] = 1'b0;
    tick();
    chk("wr_c3_done", 32'(m0_done[0]), 32'd0);
    chk("wr_c3_gnt",  32'(m0_gnt[0]), 32'd0);
    chk("wr_c3_hold", bus_addr[0], 32'h4);
    chk("wr_c3_rdd",  m0_rd_data[0], 32'd0);

    // m1 read, RD_LAT=1: data valid only in cycle 2
    m1_req[0] = 1'b1; m1_wr[0] = 1'b0; m1_addr[0] = 32'h8; bus_rd_data[0] = 32'hDEAD;
    tick();
    chk("rd_c1_rd",   32'(bus_rd[0]), 32'd1);
    chk("rd_c1_wr",   32'(bus_wr[0]), 32'd0);
    chk("rd_c1_gnt",  32'({m0_gnt[0], m1_gnt[0]}), 32'b01);
    chk("rd_c1_addr", bus_addr[0], 32'h8);
    tick();
    bus_rd_data[0] = 32'h1234;
    chk("rd_c2_cs",   32'(bus_cs[0]), 32'd0);
    chk("rd_c2_done", 32'(m1_done[0]), 32'd0);
    tick();
    bus_rd_data[0] = 32'hBEEF;
    chk("rd_c3_done", 32'(m1_done[0]), 32'd1);
    chk("rd_c3_data", m1_rd_data[0], 32'h1234);
    chk("rd_c3_m0",   m0_rd_data[0], 32'd0);
    m1_req[0] = 1'b0;
    tick();
    chk("rd_c4_done", 32'(m1_done[0]), 32'd0);
    chk("rd_c4_gnt",  32'(m1_gnt[0]), 32'd0);

    // Round-robin with both requests held: m0, m1, m0, m1
    pulse_reset();
    m0_req[0] = 1'b1; m0_wr[0] = 1'b1; m0_addr[0] = 32'h10; m0_wr_data[0] = 32'h11;
    m1_req[0] = 1'b1; m1_wr[0] = 1'b1; m1_addr[0] = 32'h20; m1_wr_data[0] = 32'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt",  32'({m0_gnt[0], m1_gnt[0]}), (k % 2 == 0) ? 32'b10 : 32'b01);
      chk("rr_addr", bus_addr[0], (k % 2 == 0) ? 32'h10 : 32'h20);
      tick();
      chk("rr_done", 32'({m0_done[0], m1_done[0]}), (k % 2 == 0) ? 32'b10 : 32'b01);
      if (k == 3) begin
        m0_req[0] = 1'b0;
        m1_req[0] = 1'b0;
      end
      tick();
      chk("rr_gap",  32'({m0_gnt[0], m1_gnt[0], bus_cs[0]}), 32'd0);
    end

    // Fixed priority: m0 wins every time
    m0_req[2] = 1'b1; m0_wr[2] = 1'b1; m0_addr[2] = 32'h50;
    m1_req[2] = 1'b1; m1_wr[2] = 1'b1; m1_addr[2] = 32'h60;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fp_gnt",  32'({m0_gnt[2], m1_gnt[2]}), 32'b10);
      chk("fp_addr", bus_addr[2], 32'h50);
      tick();
      chk("fp_done", 32'({m0_done[2], m1_done[2], m1_gnt[2]}), 32'b100);
      tick();
      chk("fp_gap",  32'({m0_gnt[2], m1_gnt[2]}), 32'd0);
    end
    m0_req[2] = 1'b0; m1_req[2] = 1'b0;

    // Reset during WAIT of an m0 read abandons it; m0 wins the tie afterwards
    m0_req[0] = 1'b1; m0_wr[0] = 1'b0; m0_addr[0] = 32'h30;
    tick();
    chk("ab_c1_rd", 32'(bus_rd[0]), 32'd1);
    tick();
    chk("ab_wait_cs",  32'(bus_cs[0]), 32'd0);
    chk("ab_wait_gnt", 32'(m0_gnt[0]), 32'd1);
    bus_rd_data[0] = 32'h5555;
    #1;
    reset = 1'b0;
    #1;
    chk("ab_rst_gnt",  32'({m0_gnt[0], m1_gnt[0]}), 32'd0);
    chk("ab_rst_addr", bus_addr[0], 32'd0);
    chk("ab_rst_bus",  32'({bus_cs[0], bus_rd[0], bus_wr[0]}), 32'd0);
    tick();
    chk("ab_nodone", 32'(m0_done[0]), 32'd0);
    chk("ab_nordd",  m0_rd_data[0], 32'd0);
    m1_req[0] = 1'b1; m1_wr[0] = 1'b1; m1_addr[0] = 32'h38;
    reset = 1'b1;
    tick();
    chk("ab_tie_gnt",  32'({m0_gnt[0], m1_gnt[0]}), 32'b10);
    chk("ab_tie_addr", bus_addr[0], 32'h30);
    tick();
    bus_rd_data[0] = 32'h7777;
    tick();
    chk("ab_rd_done", 32'(m0_done[0]), 32'd1);
    chk("ab_rd_data", m0_rd_data[0], 32'h7777);
    m0_req[0] = 1'b0;
    tick();
    tick();
    chk("ab_m1_gnt", 32'({m0_gnt[0], m1_gnt[0]}), 32'b01);
    tick();
    chk("ab_m1_done", 32'(m1_done[0]), 32'd1);
    m1_req[0] = 1'b0;
    tick();

    // RD_LAT=3 with bus data changing every cycle: capture the value present in ISSUE+3
    m0_req[1] = 1'b1; m0_wr[1] = 1'b0; m0_addr[1] = 32'h40; bus_rd_data[1] = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus_rd_data[1] = 32'h100 + 32'(k);
      if (k == 1) chk("l3_issue", 32'(bus_rd[1]), 32'd1);
      if (k == 4) chk("l3_early", 32'(m0_done[1]), 32'd0);
    end
    chk("l3_done", 32'(m0_done[1]), 32'd1);
    chk("l3_data", m0_rd_data[1], 32'h104);
    m0_req[1] = 1'b0;
    tick();
    m0_req[1] = 1'b1; m0_wr[1] = 1'b1; m0_addr[1] = 32'h44; m0_wr_data[1] = 32'h99;
    tick();
    chk("l3_wr_strobe", 32'({bus_cs[1], bus_wr[1], bus_rd[1]}), 32'b110);
    tick();
    chk("l3_wr_done", 32'(m0_done[1]), 32'd1);
    chk("l3_wr_keep", m0_rd_data[1], 32'h104);
    m0_req[1] = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
